qpu_exu_qevt_sched: RTL and testbench

//  Timed event scheduler that sits between the QIU write-back port and the

---
 rtl/qpu_exu_qevt_sched.sv | 130 +++++++++++++
 tb/tb_qpu_exu_qevt_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_qevt_sched.sv
// Timed event scheduler: in-order queue of QIU events, released as a registered strobe in the cycle the
// timeline equals tdata (2 cycles minimum after push); evt_i_ready drops when full, output has no backpressure.
module qpu_exu_qevt_sched #(
  parameter int EDATA_W = 64,
  parameter int OPR_W   = 10,
  parameter int TIME_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               evt_i_valid,
  output logic               evt_i_ready,
  input  logic [EDATA_W-1:0] evt_i_edata,
  input  logic [OPR_W-1:0]   evt_i_oprand,
  input  logic [TIME_W-1:0]  evt_i_tdata,
  input  logic               tmr_en,
  input  logic               tmr_clr,
  output logic [TIME_W-1:0]  tmr_o_time,
  output logic               evt_o_valid,
  output logic [EDATA_W-1:0] evt_o_edata,
  output logic [OPR_W-1:0]   evt_o_oprand,
  output logic               late_o,
  input  logic               late_clr,
  output logic               q_empty_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_t;

  state_t             state, state_nxt;
  logic [EDATA_W-1:0] q_edata  [DEPTH];
  logic [OPR_W-1:0]   q_oprand [DEPTH];
  logic [TIME_W-1:0]  q_tdata  [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr, rd_ptr_inc;
  logic [AW:0]        cnt, cnt_nxt;
  logic [TIME_W-1:0]  tmr, tmr_nxt;
  logic               push, pop, full;
  logic               head_due, next_due, head_late;
  logic               late;

  // Due means on-time or late: the wrap-aware difference is non-negative.
  function automatic logic is_due(input logic [TIME_W-1:0] now, input logic [TIME_W-1:0] td);
    logic [TIME_W-1:0] d;
    d = now - td;
    return ~d[TIME_W-1];
  endfunction

  function automatic logic is_late(input logic [TIME_W-1:0] now, input logic [TIME_W-1:0] td);
    logic [TIME_W-1:0] d;
    d = now - td;
    return (d != '0) && ~d[TIME_W-1];
  endfunction

  assign full        = (cnt == (AW+1)'(DEPTH));
  assign evt_i_ready = ~full;
  assign push        = evt_i_valid & evt_i_ready;
  assign pop         = (state == FIRE);
  assign cnt_nxt     = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_ptr_inc  = rd_ptr + AW'(1);

  // Decisions are taken against next cycle's timeline so the registered strobe lands on tdata.
  always_comb begin
    tmr_nxt = tmr;
    if (tmr_clr)     tmr_nxt = '0;
    else if (tmr_en) tmr_nxt = tmr + TIME_W'(1);
  end

  assign head_due  = is_due(tmr_nxt, q_tdata[rd_ptr]);
  assign next_due  = is_due(tmr_nxt, q_tdata[rd_ptr_inc]);
  assign head_late = is_late(tmr, q_tdata[rd_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      late   <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      cnt   <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      if (pop && head_late) late <= 1'b1;
      else if (late_clr)    late <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_edata[wr_ptr]  <= evt_i_edata;
      q_oprand[wr_ptr] <= evt_i_oprand;
      q_tdata[wr_ptr]  <= evt_i_tdata;
    end
  end

  // FIRE may chain into FIRE so a second due entry issues on the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push) state_nxt = WAIT;
      WAIT: if (head_due) state_nxt = FIRE;
      FIRE: begin
        if (cnt >= (AW+1)'(2) && next_due) state_nxt = FIRE;
        else if (cnt_nxt != '0)            state_nxt = WAIT;
        else                               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_o_valid  = 1'b0;
    evt_o_edata  = '0;
    evt_o_oprand = '0;
    if (state == FIRE) begin
      evt_o_valid  = 1'b1;
      evt_o_edata  = q_edata[rd_ptr];
      evt_o_oprand = q_oprand[rd_ptr];
    end
  end

  assign tmr_o_time = tmr;
  assign late_o     = late;
  assign q_empty_o  = (cnt == '0) && (state == IDLE);

endmodule

// File: tb/tb_qpu_exu_qevt_sched.sv
// Directed bench for qpu_exu_qevt_sched with an 8-bit timeline so the wrap case is reachable.
module tb_qpu_exu_qevt_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_i_valid = 1'b0;
  logic        evt_i_ready;
  logic [63:0] evt_i_edata = '0;
  logic [9:0]  evt_i_oprand = '0;
  logic [7:0]  evt_i_tdata = '0;
  logic        tmr_en = 1'b0;
  logic        tmr_clr = 1'b0;
  logic [7:0]  tmr_o_time;
  logic        evt_o_valid;
  logic [63:0] evt_o_edata;
  logic [9:0]  evt_o_oprand;
  logic        late_o;
  logic        late_clr = 1'b0;
  logic        q_empty_o;

  int checks = 0;
  int errors = 0;

  qpu_exu_qevt_sched #(.EDATA_W(64), .OPR_W(10), .TIME_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .evt_i_valid(evt_i_valid), .evt_i_ready(evt_i_ready),
    .evt_i_edata(evt_i_edata), .evt_i_oprand(evt_i_oprand), .evt_i_tdata(evt_i_tdata),
    .tmr_en(tmr_en), .tmr_clr(tmr_clr), .tmr_o_time(tmr_o_time),
    .evt_o_valid(evt_o_valid), .evt_o_edata(evt_o_edata), .evt_o_oprand(evt_o_oprand),
    .late_o(late_o), .late_clr(late_clr), .q_empty_o(q_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] ed, input logic [9:0] op, input logic [7:0] td);
    evt_i_valid  = 1'b1;
    evt_i_edata  = ed;
    evt_i_oprand = op;
    evt_i_tdata  = td;
    @(negedge clk);
    evt_i_valid  = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output logic found, output logic [7:0] t,
                             output logic [63:0] ed, output logic [9:0] op);
    found = 1'b0; t = '0; ed = '0; op = '0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (evt_o_valid) begin
        found = 1'b1; t = tmr_o_time; ed = evt_o_edata; op = evt_o_oprand;
      end
    end
  endtask

  task automatic wait_time(input int budget, input logic [7:0] target, output logic hit);
    hit = (tmr_o_time == target);
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (tmr_o_time == target);
    end
  endtask

  task automatic pulse_late_clr();
    late_clr = 1'b1;
    @(negedge clk);
    late_clr = 1'b0;
  endtask

  logic        found, hit;
  logic [7:0]  t;
  logic [63:0] ed;
  logic [9:0]  op;
  int          strobes;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", evt_i_ready, 1);
    chk("rst_empty", q_empty_o, 1);
    chk("rst_valid", evt_o_valid, 0);
    chk("rst_edata", evt_o_edata, 0);
    chk("rst_oprand", evt_o_oprand, 0);
    chk("rst_time", tmr_o_time, 0);
    chk("rst_late", late_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single on-time event at 10
    tmr_en = 1'b1;
    push(64'hA5, 10'h001, 8'd10);
    chk("t1_busy", q_empty_o, 0);
    chk("t1_no_early", evt_o_valid, 0);
    wait_strobe(30, found, t, ed, op);
    chk("t1_found", found, 1);
    chk("t1_time", t, 10);
    chk("t1_edata", ed, 64'hA5);
    chk("t1_oprand", op, 10'h001);
    @(negedge clk);
    chk("t1_one_cycle", evt_o_valid, 0);
    chk("t1_edata_idle", evt_o_edata, 0);
    chk("t1_late", late_o, 0);
    chk("t1_empty", q_empty_o, 1);

    // 2: fill the queue, in-order issue, ready returns after first pop
    push(64'd20, 10'h002, 8'd20);
    push(64'd30, 10'h004, 8'd30);
    push(64'd40, 10'h008, 8'd40);
    push(64'd50, 10'h010, 8'd50);
    chk("t2_full", evt_i_ready, 0);
    wait_strobe(15, found, t, ed, op);
    chk("t2_found20", found, 1);
    chk("t2_time20", t, 20);
    chk("t2_ed20", ed, 20);
    chk("t2_full_during_fire", evt_i_ready, 0);
    @(negedge clk);
    chk("t2_ready_back", evt_i_ready, 1);
    for (int k = 1; k < 4; k++) begin
      wait_strobe(15, found, t, ed, op);
      chk("t2_found", found, 1);
      chk("t2_time", t, 8'(20 + 10 * k));
      chk("t2_edata", ed, 64'(20 + 10 * k));
      chk("t2_oprand", op, 10'(10'h002 << k));
    end
    @(negedge clk);
    chk("t2_late", late_o, 0);

    // 3: late event at timeline 100
    wait_time(100, 8'd100, hit);
    chk("t3_reach100", hit, 1);
    push(64'h90, 10'h020, 8'd90);
    chk("t3_not_yet", evt_o_valid, 0);
    wait_strobe(5, found, t, ed, op);
    chk("t3_found", found, 1);
    chk("t3_time", t, 102);
    chk("t3_edata", ed, 64'h90);
    @(negedge clk);
    chk("t3_late_set", late_o, 1);
    pulse_late_clr();
    chk("t3_late_clr", late_o, 0);

    // 4: two entries with equal tdata issue on consecutive cycles
    tmr_clr = 1'b1;
    @(negedge clk);
    tmr_clr = 1'b0;
    chk("t4_clr", tmr_o_time, 0);
    push(64'd1, 10'h040, 8'd60);
    push(64'd2, 10'h080, 8'd60);
    wait_strobe(80, found, t, ed, op);
    chk("t4_found", found, 1);
    chk("t4_time1", t, 60);
    chk("t4_ed1", ed, 1);
    chk("t4_late_first", late_o, 0);
    @(negedge clk);
    chk("t4_valid2", evt_o_valid, 1);
    chk("t4_time2", tmr_o_time, 61);
    chk("t4_ed2", evt_o_edata, 2);
    @(negedge clk);
    chk("t4_done", evt_o_valid, 0);
    chk("t4_late", late_o, 1);
    pulse_late_clr();

    // 5: timeline near wrap, tdata=1 is early
    tmr_clr = 1'b1;
    @(negedge clk);
    tmr_clr = 1'b0;
    wait_time(300, 8'd253, hit);
    chk("t5_reach253", hit, 1);
    push(64'h55, 10'h3FF, 8'd1);
    wait_strobe(10, found, t, ed, op);
    chk("t5_found", found, 1);
    chk("t5_time", t, 1);
    chk("t5_oprand", op, 10'h3FF);
    @(negedge clk);
    chk("t5_late", late_o, 0);

    // 6: reset while waiting with 3 entries
    push(64'd7, 10'h001, 8'd200);
    push(64'd8, 10'h002, 8'd201);
    push(64'd9, 10'h004, 8'd202);
    chk("t6_busy", q_empty_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", q_empty_o, 1);
    chk("t6_rst_ready", evt_i_ready, 1);
    chk("t6_rst_time", tmr_o_time, 0);
    chk("t6_rst_valid", evt_o_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (evt_o_valid) strobes++;
    end
    chk("t6_no_strobe", strobes, 0);
    chk("t6_empty", q_empty_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
